// File: rtl/ssb_tx_envelope_seq.sv
// ssb_tx_envelope_seq
// Transmit keying sequencer feeding the SSB modulator amplitude/stdby inputs.
// Wakes the output driver, slews amplitude up to target on key-down, slews back
// to zero on key-up and returns to standby after a hang period.
module ssb_tx_envelope_seq #(
    parameter int unsigned AMP_W       = 27,
    parameter int unsigned STEP_DIV    = 16,
    parameter int unsigned WAKE_CYCLES = 256,
    parameter int unsigned HANG_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key,
    input  logic [AMP_W-1:0] target_amp,
    input  logic [AMP_W-1:0] ramp_step,
    output logic [AMP_W-1:0] amplitude,
    output logic             stdby,
    output logic             tx_on,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAKE      = 3'd1,
        S_RAMP_UP   = 3'd2,
        S_ON        = 3'd3,
        S_RAMP_DOWN = 3'd4,
        S_HANG      = 3'd5
    } state_t;

    localparam int unsigned DIV_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned CNT_MAX = (WAKE_CYCLES > HANG_CYCLES) ? WAKE_CYCLES : HANG_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HANG_LAST = CNT_W'(HANG_CYCLES - 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [AMP_W-1:0] r_amp;
    logic             r_stdby;
    logic             r_tx_on;

    state_t           w_state_nxt;
    logic [AMP_W-1:0] w_amp_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_change;
    logic             w_tick;
    logic [AMP_W-1:0] w_step;
    logic [AMP_W:0]   w_amp_x;
    logic [AMP_W:0]   w_tgt_x;
    logic [AMP_W:0]   w_step_x;
    logic [AMP_W:0]   w_up_sum;
    logic [AMP_W:0]   w_dn_lim;
    logic [AMP_W-1:0] w_toward;
    logic [AMP_W-1:0] w_down;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_step   = (ramp_step == '0) ? AMP_W'(1) : ramp_step;
    assign w_amp_x  = {1'b0, r_amp};
    assign w_tgt_x  = {1'b0, target_amp};
    assign w_step_x = {1'b0, w_step};
    assign w_up_sum = w_amp_x + w_step_x;
    assign w_dn_lim = w_tgt_x + w_step_x;

    // Slew arithmetic: one extra bit so the sums never wrap; results saturate at target or 0.
    always_comb begin
        w_toward = target_amp;
        if (r_amp < target_amp) begin
            w_toward = (w_up_sum > w_tgt_x) ? target_amp : w_up_sum[AMP_W-1:0];
        end else if (r_amp > target_amp) begin
            w_toward = (w_amp_x > w_dn_lim) ? (r_amp - w_step) : target_amp;
        end
        w_down = (r_amp > w_step) ? (r_amp - w_step) : '0;
    end

    // Next-state and next-amplitude; key changes take priority over count/amp completion.
    always_comb begin
        w_state_nxt = r_state;
        w_amp_nxt   = r_amp;
        case (r_state)
            S_IDLE: begin
                w_amp_nxt = '0;
                if (key) w_state_nxt = S_WAKE;
            end
            S_WAKE: begin
                w_amp_nxt = '0;
                if (!key)                   w_state_nxt = S_HANG;
                else if (r_cnt == WAKE_LAST) w_state_nxt = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (!key) begin
                    w_state_nxt = S_RAMP_DOWN;
                end else if (w_tick) begin
                    w_amp_nxt = w_toward;
                    if (w_toward == target_amp) w_state_nxt = S_ON;
                end
            end
            S_ON: begin
                if (!key)        w_state_nxt = S_RAMP_DOWN;
                else if (w_tick) w_amp_nxt   = w_toward;
            end
            S_RAMP_DOWN: begin
                if (key) begin
                    w_state_nxt = S_RAMP_UP;
                end else if (w_tick) begin
                    w_amp_nxt = w_down;
                    if (w_down == '0) w_state_nxt = S_HANG;
                end
            end
            S_HANG: begin
                w_amp_nxt = '0;
                if (key)                     w_state_nxt = S_RAMP_UP;
                else if (r_cnt == HANG_LAST) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_amp_nxt   = '0;
            end
        endcase
    end

    // Divider and wake/hang counter restart on every state change.
    always_comb begin
        w_change  = (w_state_nxt != r_state);
        w_div_nxt = (w_change || w_tick) ? '0 : r_div + DIV_W'(1);
        if (w_change || !((r_state == S_WAKE) || (r_state == S_HANG))) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // State and registered outputs, all updated on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_amp   <= '0;
            r_stdby <= 1'b1;
            r_tx_on <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_amp   <= w_amp_nxt;
            r_stdby <= (w_state_nxt == S_IDLE);
            r_tx_on <= (w_state_nxt == S_RAMP_UP) || (w_state_nxt == S_ON);
        end
    end

    assign amplitude = r_amp;
    assign stdby     = r_stdby;
    assign tx_on     = r_tx_on;
    assign state     = r_state;

endmodule

// File: tb/tb_ssb_tx_envelope_seq.sv
// Testbench for ssb_tx_envelope_seq: directed keying scenarios; every change of the
// output tuple is popped from an expected-event queue and compared, including the
// number of clocks since the previous change where that is fixed.
module tb_ssb_tx_envelope_seq;

    localparam int AW = 27;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WAKE = 3'd1, ST_RU = 3'd2,
                           ST_ON = 3'd3, ST_RD = 3'd4, ST_HANG = 3'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key = 1'b0;
    logic [AW-1:0] target_amp = '0;
    logic [AW-1:0] ramp_step = '0;
    logic [AW-1:0] amplitude;
    logic          stdby;
    logic          tx_on;
    logic [2:0]    state;

    ssb_tx_envelope_seq #(
        .AMP_W(AW), .STEP_DIV(4), .WAKE_CYCLES(16), .HANG_CYCLES(32)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .target_amp(target_amp), .ramp_step(ramp_step),
        .amplitude(amplitude), .stdby(stdby), .tx_on(tx_on), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    st;
        logic [AW-1:0] amp;
        logic          sb;
        logic          tx;
        int            gap;   // clocks since previous change; 0 = not checked
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          ev = 0;
    logic [31:0] last_obs;

    always @(posedge clk) cyc++;

    task automatic push(input logic [2:0] st, input logic [AW-1:0] amp, input int gap);
        exp_t e;
        e.st  = st;
        e.amp = amp;
        e.sb  = (st == ST_IDLE);
        e.tx  = (st == ST_RU) || (st == ST_ON);
        e.gap = gap;
        q.push_back(e);
    endtask

    // Monitor: on each output change, pop and compare against the scoreboard.
    always @(negedge clk) begin
        logic [31:0] cur;
        exp_t        e;
        bit          ok;
        cur = {state, amplitude, stdby, tx_on};
        if (cur !== last_obs) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected ev%0d: st=%0d amp=%0d stdby=%0b tx_on=%0b",
                         ev, state, amplitude, stdby, tx_on);
            end else begin
                e  = q.pop_front();
                ok = (state === e.st) && (amplitude === e.amp) && (stdby === e.sb) &&
                     (tx_on === e.tx) && ((e.gap == 0) || ((cyc - last_cyc) == e.gap));
                if (!ok) begin
                    errors++;
                    $display("FAIL ev%0d: got st=%0d amp=%0d stdby=%0b tx_on=%0b gap=%0d, want st=%0d amp=%0d stdby=%0b tx_on=%0b gap=%0d",
                             ev, state, amplitude, stdby, tx_on, cyc - last_cyc,
                             e.st, e.amp, e.sb, e.tx, e.gap);
                end
            end
            ev++;
            last_obs = cur;
            last_cyc = cyc;
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #2;
            if (state == s) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_state: state=%0d, wanted %0d", state, s);
    endtask

    task automatic wait_amp(input logic [AW-1:0] a, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #2;
            if (amplitude == a) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_amp: amp=%0d, wanted %0d", amplitude, a);
    endtask

    initial begin
        // 1: reset
        push(ST_IDLE, '0, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);

        // 2: ramp up in steps of 100 to 1000
        #2;
        target_amp = AW'(1000);
        ramp_step  = AW'(100);
        push(ST_WAKE, '0, 0);
        push(ST_RU, '0, 16);
        for (int unsigned i = 1; i <= 9; i++) push(ST_RU, AW'(i * 100), 4);
        push(ST_ON, AW'(1000), 4);
        key = 1'b1;
        wait_state(ST_ON, 200);

        // 3: ramp down in steps of 300, hang, standby
        ramp_step = AW'(300);
        push(ST_RD, AW'(1000), 0);
        push(ST_RD, AW'(700), 4);
        push(ST_RD, AW'(400), 4);
        push(ST_RD, AW'(100), 4);
        push(ST_HANG, '0, 4);
        push(ST_IDLE, '0, 32);
        key = 1'b0;
        wait_state(ST_IDLE, 200);

        // 4: re-key during ramp-down at amp=400
        push(ST_WAKE, '0, 0);
        push(ST_RU, '0, 16);
        push(ST_RU, AW'(300), 4);
        push(ST_RU, AW'(600), 4);
        push(ST_RU, AW'(900), 4);
        push(ST_ON, AW'(1000), 4);
        push(ST_RD, AW'(1000), 0);
        push(ST_RD, AW'(700), 4);
        push(ST_RD, AW'(400), 4);
        push(ST_RU, AW'(400), 1);
        push(ST_RU, AW'(700), 4);
        push(ST_ON, AW'(1000), 4);
        key = 1'b1;
        wait_state(ST_ON, 200);
        key = 1'b0;
        wait_amp(AW'(400), 100);
        key = 1'b1;
        wait_state(ST_ON, 100);

        // 5: re-key on the 10th clock of hang, no wake period
        push(ST_RD, AW'(1000), 0);
        push(ST_RD, AW'(700), 4);
        push(ST_RD, AW'(400), 4);
        push(ST_RD, AW'(100), 4);
        push(ST_HANG, '0, 4);
        push(ST_RU, '0, 10);
        push(ST_RU, AW'(300), 4);
        push(ST_RU, AW'(600), 4);
        push(ST_RU, AW'(900), 4);
        push(ST_ON, AW'(1000), 4);
        key = 1'b0;
        wait_state(ST_HANG, 100);
        repeat (9) @(posedge clk);
        #2 key = 1'b1;
        wait_state(ST_ON, 100);

        // 6a: ramp_step=0 behaves as 1; then a step larger than amp drops straight to 0
        target_amp = AW'(1003);
        ramp_step  = '0;
        push(ST_ON, AW'(1001), 0);
        push(ST_ON, AW'(1002), 4);
        push(ST_ON, AW'(1003), 4);
        wait_amp(AW'(1003), 100);
        ramp_step = AW'(2000);
        push(ST_RD, AW'(1003), 0);
        push(ST_HANG, '0, 4);
        push(ST_IDLE, '0, 32);
        key = 1'b0;
        wait_state(ST_IDLE, 100);

        // 6b: full-scale target with half-scale step saturates; target=0 stays in ON
        target_amp = AW'(134217727);
        ramp_step  = AW'(67108864);
        push(ST_WAKE, '0, 0);
        push(ST_RU, '0, 16);
        push(ST_RU, AW'(67108864), 4);
        push(ST_ON, AW'(134217727), 4);
        key = 1'b1;
        wait_state(ST_ON, 100);
        target_amp = '0;
        push(ST_ON, AW'(67108863), 0);
        push(ST_ON, '0, 4);
        wait_amp('0, 100);
        repeat (12) @(posedge clk);

        // 6c: reset while ON returns to reset values on the next clock
        #2;
        target_amp = AW'(500);
        ramp_step  = AW'(500);
        push(ST_ON, AW'(500), 0);
        wait_amp(AW'(500), 100);
        push(ST_IDLE, '0, 1);
        rst = 1'b0;
        key = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (10) @(posedge clk);

        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
